// File: rtl/dca_matrix_word2row_pkg.sv
// Shared matrix/tensor dimensions for the dca word-to-row packer and its
// neighbouring load stages.
package dca_matrix_word2row_pkg;

    localparam int DEF_BW_TENSOR_SCALAR = 16;
    localparam int DEF_MATRIX_NUM_COL   = 4;
    localparam int DEF_MATRIX_NUM_ROW   = 4;
    localparam int DEF_BW_WORD          = 32;

    function automatic int beats_per_row(input int bw_row, input int bw_word);
        return bw_row / bw_word;
    endfunction

endpackage

// File: rtl/dca_matrix_word2row_counter.sv
// One-hot wrap-around counter; bit k set means count k.
module ERVP_COUNTER_WITH_ONEHOT_ENCODING #(
    parameter int COUNT_LENGTH = 4
) (
    input  logic                    clk,
    input  logic                    rstnn,
    input  logic                    clear,
    input  logic                    enable,
    output logic [COUNT_LENGTH-1:0] value,
    output logic                    is_first_count,
    output logic                    is_last_count
);

    localparam logic [COUNT_LENGTH-1:0] FIRST = COUNT_LENGTH'(1);

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn)
            value <= FIRST;
        else if (clear)
            value <= FIRST;
        else if (enable)
            value <= (value << 1) | (value >> (COUNT_LENGTH - 1));
    end

    assign is_first_count = value[0];
    assign is_last_count  = value[COUNT_LENGTH-1];

endmodule

// File: rtl/dca_matrix_word2row.sv
// Packs a narrow word stream into tensor rows of MATRIX_NUM_COL scalars,
// zero-padding short final rows and dropping rows beyond MATRIX_NUM_ROW.
module dca_matrix_word2row
    import dca_matrix_word2row_pkg::*;
#(
    parameter int BW_TENSOR_SCALAR = DEF_BW_TENSOR_SCALAR,
    parameter int MATRIX_NUM_COL   = DEF_MATRIX_NUM_COL,
    parameter int MATRIX_NUM_ROW   = DEF_MATRIX_NUM_ROW,
    parameter int BW_WORD          = DEF_BW_WORD
) (
    input  logic                                       clk,
    input  logic                                       rstnn,
    input  logic                                       clear,
    input  logic                                       enable,
    output logic                                       busy,
    input  logic                                       word_wvalid,
    input  logic                                       word_wlast,
    input  logic [BW_WORD-1:0]                         word_wdata,
    output logic                                       word_wready,
    output logic                                       load_tensor_row_wvalid,
    output logic                                       load_tensor_row_wlast,
    output logic [MATRIX_NUM_COL*BW_TENSOR_SCALAR-1:0] load_tensor_row_wdata,
    input  logic                                       load_tensor_row_wready,
    output logic                                       overflow
);

    localparam int BW_TENSOR_ROW = MATRIX_NUM_COL * BW_TENSOR_SCALAR;
    localparam int BEATS_PER_ROW = beats_per_row(BW_TENSOR_ROW, BW_WORD);
    localparam int BW_BEAT       = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
    localparam logic [BW_BEAT-1:0] LAST_BEAT = BW_BEAT'(BEATS_PER_ROW - 1);
    localparam logic [BW_TENSOR_ROW-1:0] TENSOR_ZERO = '0;

    localparam logic [0:0] FILL  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]               state;
    logic [BW_BEAT-1:0]       beat_cnt;
    logic [BW_TENSOR_ROW-1:0] asm_buf;
    logic [BW_TENSOR_ROW-1:0] row_next;
    logic                     out_valid;
    logic                     out_last;
    logic [BW_TENSOR_ROW-1:0] out_data;

    logic [MATRIX_NUM_ROW-1:0] row_onehot;
    logic row_first;
    logic row_last;

    logic completing;
    logic can_load;
    logic accept;
    logic pop;
    logic fill_done;
    logic row_restart;
    logic row_advance;

    // Buffer upper slots are always zero, so a short row is padded for free.
    always_comb begin
        row_next = asm_buf;
        row_next[int'(beat_cnt)*BW_WORD +: BW_WORD] = word_wdata;
    end

    assign completing  = (beat_cnt == LAST_BEAT) | word_wlast;
    assign can_load    = ~out_valid | load_tensor_row_wready;
    assign word_wready = enable & ((state == DRAIN) | ~completing | can_load);
    assign accept      = word_wvalid & word_wready;

    assign load_tensor_row_wvalid = enable & out_valid;
    assign load_tensor_row_wlast  = out_last;
    assign load_tensor_row_wdata  = out_data;
    assign pop = load_tensor_row_wvalid & load_tensor_row_wready;

    assign fill_done   = (state == FILL) & accept & completing;
    assign row_restart = fill_done & (word_wlast | row_last);
    assign row_advance = fill_done & ~word_wlast & ~row_last;

    ERVP_COUNTER_WITH_ONEHOT_ENCODING #(
        .COUNT_LENGTH(MATRIX_NUM_ROW)
    ) i_row_counter (
        .clk            (clk),
        .rstnn          (rstnn),
        .clear          (clear | row_restart),
        .enable         (row_advance),
        .value          (row_onehot),
        .is_first_count (row_first),
        .is_last_count  (row_last)
    );

    assign busy = (state != FILL) | (beat_cnt != '0) | ~row_first | out_valid;

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state     <= FILL;
            beat_cnt  <= '0;
            asm_buf   <= TENSOR_ZERO;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= TENSOR_ZERO;
            overflow  <= 1'b0;
        end else if (clear) begin
            state     <= FILL;
            beat_cnt  <= '0;
            asm_buf   <= TENSOR_ZERO;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= TENSOR_ZERO;
            overflow  <= 1'b0;
        end else if (enable) begin
            if (pop)
                out_valid <= 1'b0;
            if (state == FILL) begin
                if (accept) begin
                    if (completing) begin
                        // A refill in the same cycle as a pop overrides the clear above.
                        out_valid <= 1'b1;
                        out_data  <= row_next;
                        asm_buf   <= TENSOR_ZERO;
                        beat_cnt  <= '0;
                        if (word_wlast) begin
                            out_last <= 1'b1;
                        end else if (row_last) begin
                            out_last <= 1'b1;
                            overflow <= 1'b1;
                            state    <= DRAIN;
                        end else begin
                            out_last <= 1'b0;
                        end
                    end else begin
                        asm_buf  <= row_next;
                        beat_cnt <= beat_cnt + BW_BEAT'(1);
                    end
                end
            end else if (accept && word_wlast) begin
                state <= FILL;
            end
        end
    end

endmodule

// File: tb/tb_dca_matrix_word2row.sv
// Directed-vector bench for dca_matrix_word2row with a queue-based row scoreboard.
module tb_dca_matrix_word2row;

    logic        clk = 1'b0;
    logic        rstnn;
    logic        clear;
    logic        enable;
    logic        busy;
    logic        word_wvalid;
    logic        word_wlast;
    logic [31:0] word_wdata;
    logic        word_wready;
    logic        row_wvalid;
    logic        row_wlast;
    logic [63:0] row_wdata;
    logic        row_ready;
    logic        overflow;

    typedef struct packed {
        logic        last;
        logic [63:0] data;
    } row_t;

    row_t exp_q[$];
    row_t mon_exp;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cur_idx     = 0;

    always #5 clk = ~clk;

    dca_matrix_word2row #(
        .BW_TENSOR_SCALAR(16),
        .MATRIX_NUM_COL  (4),
        .MATRIX_NUM_ROW  (4),
        .BW_WORD         (32)
    ) dut (
        .clk                    (clk),
        .rstnn                  (rstnn),
        .clear                  (clear),
        .enable                 (enable),
        .busy                   (busy),
        .word_wvalid            (word_wvalid),
        .word_wlast             (word_wlast),
        .word_wdata             (word_wdata),
        .word_wready            (word_wready),
        .load_tensor_row_wvalid (row_wvalid),
        .load_tensor_row_wlast  (row_wlast),
        .load_tensor_row_wdata  (row_wdata),
        .load_tensor_row_wready (row_ready),
        .overflow               (overflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Handshake is decided by values stable since the previous posedge.
    always @(negedge clk) begin
        if (rstnn === 1'b1 && row_wvalid === 1'b1 && row_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_row: got %h last %b expected no row", row_wdata, row_wlast);
            end else begin
                mon_exp = exp_q.pop_front();
                check("row_data", row_wdata, mon_exp.data);
                check("row_last", {63'd0, row_wlast}, {63'd0, mon_exp.last});
            end
        end
    end

    task automatic push_row(input logic [63:0] d, input logic l);
        row_t r;
        r.data = d;
        r.last = l;
        exp_q.push_back(r);
    endtask

    task automatic send_word(input logic [31:0] d, input logic l, input int idx);
        int t = 0;
        word_wvalid = 1'b1;
        word_wdata  = d;
        word_wlast  = l;
        cur_idx     = idx;
        forever begin
            @(negedge clk);
            if (word_wready === 1'b1) break;
            t++;
            if (t > 100) begin
                vectors++;
                miscompares++;
                $display("FAIL word_accept_timeout: got no wready for word %0d expected accept", idx);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        word_wvalid = 1'b0;
        word_wlast  = 1'b0;
        cur_idx     = 0;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        @(posedge clk);
        #1;
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1);
    end

    initial begin
        rstnn = 1'b0;
        clear = 1'b0;
        enable = 1'b1;
        row_ready = 1'b1;
        idle();
        word_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rstnn = 1'b1;
        #1;
        check("reset_row_wvalid", {63'd0, row_wvalid}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_overflow", {63'd0, overflow}, 64'd0);
        check("reset_word_wready", {63'd0, word_wready}, 64'd1);
        @(posedge clk);
        #1;

        // 1: full matrix
        push_row(64'h00000002_00000001, 1'b0);
        push_row(64'h00000004_00000003, 1'b0);
        push_row(64'h00000006_00000005, 1'b0);
        push_row(64'h00000008_00000007, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            send_word(32'(i), (i == 8), i);
            if (i == 3) check("full_busy_mid", {63'd0, busy}, 64'd1);
        end
        idle();
        wait_drain("full_drain");
        check("full_busy_after", {63'd0, busy}, 64'd0);
        check("full_overflow", {63'd0, overflow}, 64'd0);

        // 2: partial final row
        push_row(64'hBBBB0002_AAAA0001, 1'b0);
        push_row(64'h00000000_CCCC0003, 1'b1);
        send_word(32'hAAAA0001, 1'b0, 1);
        send_word(32'hBBBB0002, 1'b0, 2);
        send_word(32'hCCCC0003, 1'b1, 3);
        idle();
        wait_drain("partial_drain");
        check("partial_busy_after", {63'd0, busy}, 64'd0);

        // 3: backpressure after row0
        row_ready = 1'b0;
        push_row(64'h00000102_00000101, 1'b0);
        push_row(64'h00000104_00000103, 1'b0);
        push_row(64'h00000106_00000105, 1'b0);
        push_row(64'h00000108_00000107, 1'b1);
        fork
            begin
                for (int i = 1; i <= 8; i++)
                    send_word(32'h100 + 32'(i), (i == 8), i);
                idle();
            end
            begin
                int t = 0;
                do begin
                    @(posedge clk);
                    #2;
                    t++;
                end while (row_wvalid !== 1'b1 && t < 100);
                if (row_wvalid !== 1'b1)
                    check("bp_row0_valid", {63'd0, row_wvalid}, 64'd1);
                repeat (5) begin
                    if (word_wvalid && cur_idx == 4)
                        check("bp_word_wready", {63'd0, word_wready}, 64'd0);
                    @(posedge clk);
                    #2;
                end
                row_ready = 1'b1;
            end
        join
        wait_drain("bp_drain");

        // 4: overflow, then a normal matrix
        push_row(64'h00000202_00000201, 1'b0);
        push_row(64'h00000204_00000203, 1'b0);
        push_row(64'h00000206_00000205, 1'b0);
        push_row(64'h00000208_00000207, 1'b1);
        for (int i = 1; i <= 11; i++)
            send_word(32'h200 + 32'(i), (i == 11), i);
        idle();
        wait_drain("ovf_drain");
        check("ovf_flag", {63'd0, overflow}, 64'd1);
        check("ovf_busy_after", {63'd0, busy}, 64'd0);
        push_row(64'h00000302_00000301, 1'b1);
        send_word(32'h301, 1'b0, 1);
        send_word(32'h302, 1'b1, 2);
        idle();
        wait_drain("ovf_next_drain");
        check("ovf_sticky", {63'd0, overflow}, 64'd1);

        // 5: clear mid-row
        push_row(64'h00000402_00000401, 1'b0);
        send_word(32'h401, 1'b0, 1);
        send_word(32'h402, 1'b0, 2);
        send_word(32'h403, 1'b0, 3);
        idle();
        wait_drain("clr_pre_drain");
        check("clr_busy_before", {63'd0, busy}, 64'd1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clr_row_wvalid", {63'd0, row_wvalid}, 64'd0);
        check("clr_busy", {63'd0, busy}, 64'd0);
        check("clr_overflow", {63'd0, overflow}, 64'd0);
        push_row(64'h00000502_00000501, 1'b1);
        send_word(32'h501, 1'b0, 1);
        send_word(32'h502, 1'b1, 2);
        idle();
        wait_drain("clr_post_drain");

        // 6: enable low mid-row with a row pending
        row_ready = 1'b0;
        push_row(64'h00000602_00000601, 1'b0);
        push_row(64'h00000604_00000603, 1'b1);
        send_word(32'h601, 1'b0, 1);
        send_word(32'h602, 1'b0, 2);
        send_word(32'h603, 1'b0, 3);
        enable = 1'b0;
        word_wvalid = 1'b1;
        word_wdata = 32'h604;
        word_wlast = 1'b1;
        cur_idx = 4;
        repeat (3) begin
            @(negedge clk);
            check("en_word_wready", {63'd0, word_wready}, 64'd0);
            check("en_row_wvalid", {63'd0, row_wvalid}, 64'd0);
            @(posedge clk);
            #1;
        end
        enable = 1'b1;
        row_ready = 1'b1;
        send_word(32'h604, 1'b1, 4);
        idle();
        wait_drain("en_drain");
        check("en_busy_after", {63'd0, busy}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
